// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution and a
// 16-step shift-add multiplier that stalls decode until its result is ready.
module execute_stage (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] execute_pc,
    input  logic [15:0] execute_a,
    input  logic [15:0] execute_b,
    input  logic [15:0] execute_imm,
    input  logic [3:0]  execute_rd,
    input  logic        pcwrite_in,
    input  logic        mem2reg_in,
    input  logic        memwrite_in,
    input  logic        alusrc_in,
    input  logic [1:0]  aluin1_in,
    input  logic [1:0]  aluin2_in,
    input  logic [2:0]  alu_op,
    input  logic [15:0] em_fwd,
    input  logic [15:0] wb_fwd,
    output logic [15:0] mem_aluout,
    output logic [15:0] mem_b,
    output logic [3:0]  mem_rd,
    output logic        mem_mem2reg,
    output logic        mem_memwrite,
    output logic        branch_taken,
    output logic [15:0] branch_target,
    output logic        de_write
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [15:0] r_store;
    logic [3:0]  r_rd;
    logic        r_mem2reg;
    logic        r_memwrite;

    logic [15:0] w_op1;
    logic [15:0] w_op2;
    logic [15:0] w_store;
    logic [15:0] w_alu;
    logic [15:0] w_final;
    logic        w_is_mul;
    logic        w_start;

    assign w_is_mul = (alu_op == OP_MUL);
    assign w_start  = (r_state == S_IDLE) && w_is_mul;

    // Operand and store-data selection from register file, forwarding paths or PC.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_op1   = execute_a;
        w_op2   = alusrc_in ? execute_imm : execute_b;
        w_store = execute_b;
        case (aluin1_in)
            2'b01:   w_op1 = em_fwd;
            2'b10:   w_op1 = wb_fwd;
            2'b11:   w_op1 = execute_pc;
            default: w_op1 = execute_a;
        endcase
        case (aluin2_in)
            2'b01:   begin w_op2 = em_fwd; w_store = em_fwd; end
            2'b10:   begin w_op2 = wb_fwd; w_store = wb_fwd; end
            2'b11:   w_op2 = 16'd2;
            default: w_op2 = alusrc_in ? execute_imm : execute_b;
        endcase
    end

    // Single-cycle ALU; MUL is handled by the sequencer so its slot here is unused.
    always_comb begin
        w_alu = 16'd0;
        case (alu_op)
            OP_ADD:  w_alu = w_op1 + w_op2;
            OP_SUB:  w_alu = w_op1 - w_op2;
            OP_AND:  w_alu = w_op1 & w_op2;
            OP_OR:   w_alu = w_op1 | w_op2;
            OP_SLL:  w_alu = w_op1 << w_op2[3:0];
            OP_SRL:  w_alu = w_op1 >> w_op2[3:0];
            OP_SLT:  w_alu = {15'd0, ($signed(w_op1) < $signed(w_op2))};
            default: w_alu = 16'd0;
        endcase
    end

    // The sixteenth partial product is folded into the DONE writeback.
    assign w_final = r_acc + (r_mplier[0] ? r_mcand : 16'd0);

    // A MUL never branches; the held instruction waits for the multiplier.
    assign branch_taken  = pcwrite_in && (w_op1 == w_op2) && (r_state == S_IDLE) && !w_is_mul;
    assign branch_target = execute_pc + execute_imm;
    assign de_write      = !rst || !(w_start || (r_state == S_MUL));

    // Multiplier sequencer: IDLE captures operands, MUL iterates, DONE hands back to IDLE.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_acc      <= 16'd0;
            r_mcand    <= 16'd0;
            r_mplier   <= 16'd0;
            r_store    <= 16'd0;
            r_rd       <= 4'd0;
            r_mem2reg  <= 1'b0;
            r_memwrite <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_is_mul) begin
                        r_mcand    <= w_op1;
                        r_mplier   <= w_op2;
                        r_store    <= w_store;
                        r_rd       <= execute_rd;
                        r_mem2reg  <= mem2reg_in;
                        r_memwrite <= memwrite_in;
                        r_acc      <= 16'd0;
                        r_cnt      <= 4'd0;
                        r_state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 4'd1;
                    // Counter reaches 15 as we enter DONE, where the last step completes.
                    if (r_cnt == 4'd14) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // EM pipeline register: multiply result, bubble while multiplying, else ALU result.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            mem_aluout   <= 16'd0;
            mem_b        <= 16'd0;
            mem_rd       <= 4'd0;
            mem_mem2reg  <= 1'b0;
            mem_memwrite <= 1'b0;
        end else if (r_state == S_DONE) begin
            mem_aluout   <= w_final;
            mem_b        <= r_store;
            mem_rd       <= r_rd;
            mem_mem2reg  <= r_mem2reg;
            mem_memwrite <= r_memwrite;
        end else if (w_start || (r_state == S_MUL)) begin
            mem_aluout   <= 16'd0;
            mem_b        <= 16'd0;
            mem_rd       <= 4'd0;
            mem_mem2reg  <= 1'b0;
            mem_memwrite <= 1'b0;
        end else begin
            mem_aluout   <= w_alu;
            mem_b        <= w_store;
            mem_rd       <= execute_rd;
            mem_mem2reg  <= mem2reg_in;
            mem_memwrite <= memwrite_in;
        end
    end

endmodule
